// File: rtl/lcd_bus_mirror_if.sv
// lcd_bus_mirror_if: LCD bus tap, mirror read port and status signals for lcd_bus_mirror.
// Revision 1.0 - initial release.
`default_nettype none

interface lcd_bus_mirror_if;
  logic       lcd_rs;
  logic       lcd_e;
  logic [7:0] lcd_data;
  logic [4:0] rd_addr;
  logic [7:0] rd_data;
  logic [4:0] cursor_addr;
  logic       display_on;
  logic       cursor_on;
  logic       blink_on;
  logic       busy;
  logic       update;
  logic       err_short;
  logic       err_overrun;

  modport master (
    output lcd_rs, lcd_e, lcd_data, rd_addr,
    input  rd_data, cursor_addr, display_on, cursor_on, blink_on,
           busy, update, err_short, err_overrun
  );

  modport slave (
    input  lcd_rs, lcd_e, lcd_data, rd_addr,
    output rd_data, cursor_addr, display_on, cursor_on, blink_on,
           busy, update, err_short, err_overrun
  );
endinterface

`default_nettype wire

// File: rtl/lcd_bus_mirror.sv
// lcd_bus_mirror: passive HD44780 bus receiver keeping a 2x16 DDRAM mirror plus cursor/display state.
// Revision 1.0 - initial release.
`default_nettype none

module lcd_bus_mirror #(
  parameter int MIN_E_HIGH = 2
) (
  input logic             clk,
  input logic             rst,
  lcd_bus_mirror_if.slave bus
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;
  localparam logic [7:0] MIN_CNT  = 8'(MIN_E_HIGH);
  localparam logic [7:0] BLANK    = 8'h20;

  logic       e_q, e_p, rs_q;
  logic [7:0] d_q;
  logic       hold_rs;
  logic [7:0] hold_d;
  logic [7:0] high_cnt;
  logic       stb_ok;
  logic       err_short;

  logic [0:0] state;
  logic [5:0] clr_idx;
  logic [4:0] ac;
  logic       inc;
  logic       cgram_mode;
  logic       display_on, cursor_on, blink_on;
  logic       update;
  logic       err_overrun;
  logic [7:0] mirror [32];

  logic       fall;
  assign fall = e_p & ~e_q;

  // Input sampling, strobe width measurement and falling-edge qualification.
  always_ff @(posedge clk) begin
    if (rst) begin
      e_q       <= 1'b0;
      e_p       <= 1'b0;
      rs_q      <= 1'b0;
      d_q       <= 8'h00;
      hold_rs   <= 1'b0;
      hold_d    <= 8'h00;
      high_cnt  <= 8'h00;
      stb_ok    <= 1'b0;
      err_short <= 1'b0;
    end else begin
      e_q    <= bus.lcd_e;
      e_p    <= e_q;
      rs_q   <= bus.lcd_rs;
      d_q    <= bus.lcd_data;
      stb_ok <= 1'b0;
      if (e_q) begin
        hold_rs <= rs_q;
        hold_d  <= d_q;
        if (high_cnt != 8'hFF) high_cnt <= high_cnt + 8'd1;
      end
      if (fall) begin
        high_cnt <= 8'h00;
        stb_ok   <= (high_cnt >= MIN_CNT);
        if (high_cnt < MIN_CNT) err_short <= 1'b1;
      end
    end
  end

  // Command decode, mirror writes and the clear sweep.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      clr_idx     <= 6'd0;
      ac          <= 5'd0;
      inc         <= 1'b1;
      cgram_mode  <= 1'b0;
      display_on  <= 1'b0;
      cursor_on   <= 1'b0;
      blink_on    <= 1'b0;
      update      <= 1'b0;
      err_overrun <= 1'b0;
      for (int i = 0; i < 32; i++) mirror[i] <= BLANK;
    end else begin
      update <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (stb_ok) begin
            if (hold_rs) begin
              if (!cgram_mode) begin
                mirror[ac] <= hold_d;
                ac         <= inc ? ac + 5'd1 : ac - 5'd1;
                update     <= 1'b1;
              end
            end else begin
              casez (hold_d)
                8'b1???????: begin
                  ac         <= {hold_d[6], hold_d[3:0]};
                  cgram_mode <= 1'b0;
                  update     <= 1'b1;
                end
                8'b01??????: cgram_mode <= 1'b1;
                8'b001?????: ;
                8'b0001????: begin
                  if (!hold_d[3]) begin
                    ac     <= hold_d[2] ? ac + 5'd1 : ac - 5'd1;
                    update <= 1'b1;
                  end
                end
                8'b00001???: begin
                  display_on <= hold_d[2];
                  cursor_on  <= hold_d[1];
                  blink_on   <= hold_d[0];
                end
                8'b000001??: inc <= hold_d[1];
                8'b0000001?: begin
                  ac         <= 5'd0;
                  cgram_mode <= 1'b0;
                  update     <= 1'b1;
                end
                8'b00000001: begin
                  // Index 0 is blanked on the decode edge itself; the sweep continues from 1.
                  mirror[0] <= BLANK;
                  clr_idx   <= 6'd1;
                  state     <= ST_CLEAR;
                end
                default: ;
              endcase
            end
          end
        end
        ST_CLEAR: begin
          if (stb_ok) err_overrun <= 1'b1;
          if (clr_idx[5]) begin
            ac         <= 5'd0;
            inc        <= 1'b1;
            cgram_mode <= 1'b0;
            update     <= 1'b1;
            state      <= ST_IDLE;
          end else begin
            mirror[clr_idx[4:0]] <= BLANK;
            clr_idx              <= clr_idx + 6'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.rd_data     = mirror[bus.rd_addr];
  assign bus.cursor_addr = ac;
  assign bus.display_on  = display_on;
  assign bus.cursor_on   = cursor_on;
  assign bus.blink_on    = blink_on;
  assign bus.busy        = (state == ST_CLEAR);
  assign bus.update      = update;
  assign bus.err_short   = err_short;
  assign bus.err_overrun = err_overrun;

endmodule

`default_nettype wire

// File: tb/tb_lcd_bus_mirror.sv
// tb_lcd_bus_mirror: directed vector table plus hand-written sequences for lcd_bus_mirror.
// Revision 1.0 - initial release.
`default_nettype none

module tb_lcd_bus_mirror;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_fail;

  lcd_bus_mirror_if bus ();

  lcd_bus_mirror #(.MIN_E_HIGH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rs;
    logic [7:0] d;
    int         nhigh;
    logic       upd;
    logic [4:0] ac;
    logic [4:0] addr;
    logic [7:0] rd;
  } vec_t;

  vec_t tbl [19];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send(input logic rs, input logic [7:0] d, input int nhigh);
    @(negedge clk);
    bus.lcd_rs   = rs;
    bus.lcd_data = d;
    bus.lcd_e    = 1'b1;
    repeat (nhigh) @(negedge clk);
    bus.lcd_e    = 1'b0;
  endtask

  // Update must appear only on the third sample after the low edge of lcd_e.
  task automatic strobe_check(input logic rs, input logic [7:0] d, input int nhigh,
                              input logic upd, input logic [4:0] ac,
                              input logic [4:0] addr, input logic [7:0] rd);
    logic [3:0] seen;
    seen = 4'b0000;
    send(rs, d, nhigh);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      seen[k] = bus.update;
    end
    check($sformatf("update timing rs=%0b d=%02h", rs, d), {28'd0, seen}, upd ? 32'h4 : 32'h0);
    check($sformatf("cursor_addr rs=%0b d=%02h", rs, d), {27'd0, bus.cursor_addr}, {27'd0, ac});
    bus.rd_addr = addr;
    #1;
    check($sformatf("rd_data[%0d] rs=%0b d=%02h", addr, rs, d), {24'd0, bus.rd_data}, {24'd0, rd});
  endtask

  task automatic check_all_blank(input string name);
    for (int i = 0; i < 32; i++) begin
      bus.rd_addr = 5'(i);
      #1;
      check($sformatf("%s idx %0d", name, i), {24'd0, bus.rd_data}, 32'h20);
    end
  endtask

  task automatic check_reset_state(input string name);
    check({name, " cursor_addr"}, {27'd0, bus.cursor_addr}, 32'd0);
    check({name, " flags"},
          {23'd0, bus.display_on, bus.cursor_on, bus.blink_on, bus.busy, bus.update,
           bus.err_short, bus.err_overrun, 2'b00}, 32'd0);
    check_all_blank({name, " mirror"});
  endtask

  initial begin
    int busy_n, first_busy, upd_n;
    n_vec = 0;
    n_fail = 0;
    rst = 1'b1;
    bus.lcd_rs = 1'b0;
    bus.lcd_e = 1'b0;
    bus.lcd_data = 8'h00;
    bus.rd_addr = 5'd0;

    tbl[0]  = '{1'b0, 8'h80, 4, 1'b1, 5'd0,  5'd0,  8'h20};
    tbl[1]  = '{1'b1, 8'h48, 4, 1'b1, 5'd1,  5'd0,  8'h48};
    tbl[2]  = '{1'b1, 8'h69, 4, 1'b1, 5'd2,  5'd1,  8'h69};
    tbl[3]  = '{1'b0, 8'hCF, 2, 1'b1, 5'd31, 5'd31, 8'h20};
    tbl[4]  = '{1'b1, 8'h41, 3, 1'b1, 5'd0,  5'd31, 8'h41};
    tbl[5]  = '{1'b1, 8'h42, 2, 1'b1, 5'd1,  5'd0,  8'h42};
    tbl[6]  = '{1'b0, 8'h04, 2, 1'b0, 5'd1,  5'd0,  8'h42};
    tbl[7]  = '{1'b1, 8'h43, 5, 1'b1, 5'd0,  5'd1,  8'h43};
    tbl[8]  = '{1'b0, 8'h14, 2, 1'b1, 5'd1,  5'd1,  8'h43};
    tbl[9]  = '{1'b0, 8'h10, 2, 1'b1, 5'd0,  5'd0,  8'h42};
    tbl[10] = '{1'b0, 8'h18, 2, 1'b0, 5'd0,  5'd0,  8'h42};
    tbl[11] = '{1'b0, 8'h38, 2, 1'b0, 5'd0,  5'd0,  8'h42};
    tbl[12] = '{1'b0, 8'h06, 2, 1'b0, 5'd0,  5'd0,  8'h42};
    tbl[13] = '{1'b0, 8'h8A, 3, 1'b1, 5'd10, 5'd10, 8'h20};
    tbl[14] = '{1'b0, 8'h02, 2, 1'b1, 5'd0,  5'd31, 8'h41};
    tbl[15] = '{1'b0, 8'h00, 2, 1'b0, 5'd0,  5'd0,  8'h42};
    tbl[16] = '{1'b0, 8'h10, 2, 1'b1, 5'd31, 5'd31, 8'h41};
    tbl[17] = '{1'b0, 8'h85, 2, 1'b1, 5'd5,  5'd5,  8'h20};
    tbl[18] = '{1'b0, 8'h04, 2, 1'b0, 5'd5,  5'd0,  8'h42};

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_state("reset");

    for (int v = 0; v < 19; v++)
      strobe_check(tbl[v].rs, tbl[v].d, tbl[v].nhigh, tbl[v].upd, tbl[v].ac, tbl[v].addr, tbl[v].rd);

    // Clear sweep with an overlapping data strobe.
    busy_n = 0;
    first_busy = 0;
    upd_n = 0;
    send(1'b0, 8'h01, 4);
    fork
      begin
        for (int k = 1; k <= 60; k++) begin
          @(negedge clk);
          if (bus.busy) begin
            busy_n++;
            if (first_busy == 0) first_busy = k;
          end
          if (bus.update) upd_n++;
        end
      end
      begin
        repeat (5) @(negedge clk);
        send(1'b1, 8'h58, 2);
      end
    join
    check("clear busy length", 32'(busy_n), 32'd32);
    check("clear busy start", 32'(first_busy), 32'd3);
    check("clear update count", 32'(upd_n), 32'd1);
    check("clear err_overrun", {31'd0, bus.err_overrun}, 32'd1);
    check("clear cursor_addr", {27'd0, bus.cursor_addr}, 32'd0);
    check_all_blank("clear mirror");
    strobe_check(1'b1, 8'h61, 2, 1'b1, 5'd1, 5'd0, 8'h61);

    // Strobe below the minimum width.
    strobe_check(1'b1, 8'h77, 1, 1'b0, 5'd1, 5'd1, 8'h20);
    check("err_short", {31'd0, bus.err_short}, 32'd1);
    strobe_check(1'b0, 8'h0E, 2, 1'b0, 5'd1, 5'd1, 8'h20);
    check("display ctrl", {29'd0, bus.display_on, bus.cursor_on, bus.blink_on}, 32'b110);

    // CGRAM mode swallows data writes until a DDRAM address is set.
    strobe_check(1'b0, 8'h40, 2, 1'b0, 5'd1,  5'd1,  8'h20);
    strobe_check(1'b1, 8'h55, 2, 1'b0, 5'd1,  5'd1,  8'h20);
    strobe_check(1'b0, 8'h80, 2, 1'b1, 5'd0,  5'd0,  8'h61);
    strobe_check(1'b1, 8'h55, 2, 1'b1, 5'd1,  5'd0,  8'h55);
    strobe_check(1'b0, 8'hC4, 2, 1'b1, 5'd20, 5'd20, 8'h20);
    strobe_check(1'b1, 8'h7A, 3, 1'b1, 5'd21, 5'd20, 8'h7A);

    // Reset in the middle of a clear sweep.
    send(1'b0, 8'h01, 2);
    repeat (13) @(negedge clk);
    check("mid-clear busy", {31'd0, bus.busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_state("mid-clear reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
